serdes_rx_chk: RTL and testbench
================================

# serdes_rx_chk

Receive-side pattern checker for the SerDes link test path. It sits between the GTX receiver user interface and the local-bus register block. It locks onto a 16-bit incrementing test pattern and counts word errors and link losses. It also keeps a four-word capture window that freezes on the first data error, so the CPU can read the offending words.

## Interface
Parameters:
- SYNC_CNT, 8: consecutive correct words required in VERIFY before entering SYNC (legal range 1..15).
- LOSS_CNT, 4: consecutive wrong words in SYNC that declare link loss (legal range 1..15).

Ports:
- clk  input  1  receive user clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  16  received word, valid when rx_valid=1.
- rx_valid  input  1  word strobe; may be low on any cycle.
- rx_lock  input  1  receiver byte-aligned/locked status, level.
- clr_cnt  input  1  single-cycle pulse: clear both counters and unfreeze the capture window.
- test_rx_d0  output  16  capture window, newest word.
- test_rx_d1  output  16  capture window, newest-1.
- test_rx_d2  output  16  capture window, newest-2.
- test_rx_d3  output  16  capture window, oldest.
- data_err_cnt  output  16  data error count, saturating.
- link_err_cnt  output  16  link loss count, saturating.
- sync_ok  output  1  1 while the state machine is in SYNC.

## Operation
- **Reset values:** state=HUNT; expected=0; match/miss counters=0; all outputs 0; freeze flag=0.
- **Expected-word rule:** every accepted word (rx_valid=1 in any state) sets expected <= rx_data+1, modulo 2^16, so FFFF is followed by 0000. This applies on both match and mismatch, so the checker re-seeds itself.
- **HUNT:**
  - On rx_valid=1 with rx_lock=1: load expected, clear the match counter, go to VERIFY.
  - With rx_lock=0: words are ignored and expected is not loaded.
- **VERIFY:**
  - rx_lock=0: go to HUNT; no counting.
  - Valid word equal to expected: match counter +1; on reaching SYNC_CNT, go to SYNC and clear the miss counter.
  - Valid word not equal to expected: go to HUNT and clear the match counter; data_err_cnt is not incremented.
- **SYNC:**
  - Valid word not equal to expected: data_err_cnt +1 and miss counter +1.
  - If the miss counter reaches LOSS_CNT: link_err_cnt +1, go to HUNT.
  - Valid word equal to expected: clear the miss counter.
  - rx_lock=0: link_err_cnt +1, go to HUNT. This takes priority over word checking in the same cycle; no data error is counted for that word.
- **Counters:** saturate at 16'hFFFF and do not wrap.
- **clr_cnt:**
  - Next value of both counters is 0. Any increment in the same cycle is dropped.
  - The freeze flag clears.
  - The state machine is unaffected.
- **Capture window, freeze flag=0:**
  - Each valid word shifts in: d3<=d2, d2<=d1, d1<=d0, d0<=rx_data. This happens in all states.
  - A SYNC-state data error shifts that word in and sets the freeze flag. The window then holds the error word in d0 and the three preceding valid words in d1..d3.
  - If clr_cnt coincides with that error, the word still shifts in but the flag stays 0.
- **Capture window, freeze flag=1:** d0..d3 hold until clr_cnt.
- **sync_ok:** registered, equal to (state==SYNC).

## Timing
- Single clock domain. The upstream block provides rx_data, rx_valid and rx_lock synchronous to clk.
- Word sampled at edge N: counters, capture window, state and sync_ok reflect it immediately after edge N. This is 1-cycle latency and all outputs are registered.
- rx_lock is sampled synchronously. There is no debounce; a single low cycle during SYNC counts as one link loss.
- SYNC entry: the earliest sync_ok=1 is after the (SYNC_CNT+1)-th valid word following lock. The first word seeds expected; the next SYNC_CNT words must match.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). After deassertion, operation restarts in HUNT.
- Gaps with rx_valid=0 do not advance expected and do not count as errors.

## Test plan
- **Pattern lock:** rx_lock=1, words 0x0100,0x0101,...,0x0108 back-to-back -> sync_ok=1 after the 9th word; data_err_cnt=0; link_err_cnt=0; d0=0x0108, d3=0x0105.
- **Wrap:** in SYNC, send 0xFFFE,0xFFFF,0x0000,0x0001 -> no errors; sync_ok stays 1.
- **Single error and freeze:** in SYNC, send ...,0x0010,0x0011,0x0012,0x5555,0x5556,0x5557 -> data_err_cnt=1; window frozen at d0=0x5555, d1=0x0012, d2=0x0011, d3=0x0010; sync_ok stays 1; further words leave the window unchanged.
- **Link loss by errors:** in SYNC, send 4 consecutive wrong words (each ≠ previous+1) -> data_err_cnt=4, link_err_cnt=1, sync_ok=0 after the 4th.
- **Lock drop:** in SYNC, rx_lock=0 for one cycle with a valid wrong word -> link_err_cnt +1, data_err_cnt unchanged, state HUNT. Resending 9 pattern words restores sync_ok.
- **Clear and saturation:**
  - Force data_err_cnt to 0xFFFF via continuous errors; one more error -> stays 0xFFFF.
  - clr_cnt concurrent with an error -> both counters 0, window unfrozen; the next error re-freezes it.

Source files
------------

// File: rtl/serdes_rx_chk_if.sv
// Receive-side word stream from the GTX user interface into the pattern checker.
interface serdes_rx_chk_if;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_lock;

  modport master (output rx_data, output rx_valid, output rx_lock);
  modport slave  (input  rx_data, input  rx_valid, input  rx_lock);
endinterface

// File: rtl/serdes_rx_chk.sv
// Incrementing 16-bit pattern checker: HUNT/VERIFY/SYNC lock, saturating error counters and a
// four-word capture window that freezes on the first in-sync data error.
module serdes_rx_chk #(
  parameter int unsigned SYNC_CNT = 8,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serdes_rx_chk_if.slave        rx,
  input  logic                  clr_cnt,
  output logic [15:0]           test_rx_d0,
  output logic [15:0]           test_rx_d1,
  output logic [15:0]           test_rx_d2,
  output logic [15:0]           test_rx_d3,
  output logic [15:0]           data_err_cnt,
  output logic [15:0]           link_err_cnt,
  output logic                  sync_ok
);

  localparam logic [3:0] SyncTgt = 4'(SYNC_CNT);
  localparam logic [3:0] LossTgt = 4'(LOSS_CNT);

  typedef enum logic [1:0] {StHunt, StVerify, StSync} state_e;

  state_e            state_q, state_d;
  logic [15:0]       expected_q, expected_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic [15:0]       data_err_q, data_err_d;
  logic [15:0]       link_err_q, link_err_d;
  logic              freeze_q, freeze_d;
  logic [3:0][15:0]  win_q, win_d;
  logic              sync_ok_q;

  logic              word_ok;
  logic              load_exp;
  logic              data_inc;
  logic              link_inc;
  logic [3:0]        match_inc;
  logic [3:0]        miss_inc;

  assign word_ok   = (rx.rx_data == expected_q);
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    miss_d   = miss_q;
    data_inc = 1'b0;
    link_inc = 1'b0;
    load_exp = rx.rx_valid;
    unique case (state_q)
      StHunt: begin
        // Unlocked words are not trusted enough to seed the expected value.
        load_exp = rx.rx_valid && rx.rx_lock;
        if (load_exp) begin
          match_d = 4'd0;
          state_d = StVerify;
        end
      end
      StVerify: begin
        if (!rx.rx_lock) begin
          state_d = StHunt;
        end else if (rx.rx_valid) begin
          if (word_ok) begin
            match_d = match_inc;
            if (match_inc == SyncTgt) begin
              state_d = StSync;
              miss_d  = 4'd0;
            end
          end else begin
            match_d = 4'd0;
            state_d = StHunt;
          end
        end
      end
      StSync: begin
        // Lock loss wins over word checking; that word is not a data error.
        if (!rx.rx_lock) begin
          link_inc = 1'b1;
          state_d  = StHunt;
        end else if (rx.rx_valid) begin
          if (word_ok) begin
            miss_d = 4'd0;
          end else begin
            data_inc = 1'b1;
            miss_d   = miss_inc;
            if (miss_inc == LossTgt) begin
              link_inc = 1'b1;
              state_d  = StHunt;
            end
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    expected_d = load_exp ? rx.rx_data + 16'd1 : expected_q;

    data_err_d = data_err_q;
    if (clr_cnt) begin
      data_err_d = 16'd0;
    end else if (data_inc && (data_err_q != 16'hFFFF)) begin
      data_err_d = data_err_q + 16'd1;
    end

    link_err_d = link_err_q;
    if (clr_cnt) begin
      link_err_d = 16'd0;
    end else if (link_inc && (link_err_q != 16'hFFFF)) begin
      link_err_d = link_err_q + 16'd1;
    end

    win_d = win_q;
    if (rx.rx_valid && !freeze_q) begin
      win_d = {win_q[2:0], rx.rx_data};
    end
    freeze_d = clr_cnt ? 1'b0 : (freeze_q | data_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHunt;
      expected_q <= 16'd0;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      data_err_q <= 16'd0;
      link_err_q <= 16'd0;
      freeze_q   <= 1'b0;
      win_q      <= '0;
      sync_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      data_err_q <= data_err_d;
      link_err_q <= link_err_d;
      freeze_q   <= freeze_d;
      win_q      <= win_d;
      sync_ok_q  <= (state_d == StSync);
    end
  end

  assign test_rx_d0   = win_q[0];
  assign test_rx_d1   = win_q[1];
  assign test_rx_d2   = win_q[2];
  assign test_rx_d3   = win_q[3];
  assign data_err_cnt = data_err_q;
  assign link_err_cnt = link_err_q;
  assign sync_ok      = sync_ok_q;

endmodule

// File: tb/tb_serdes_rx_chk.sv
// Directed bench for serdes_rx_chk; a second instance with a long loss threshold is used for
// counter saturation.
module tb_serdes_rx_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_cnt = 1'b0;
  always #5 clk = ~clk;

  serdes_rx_chk_if bus ();

  logic [15:0] d0, d1, d2, d3, derr, lerr;
  logic        sok;
  logic [15:0] s_d0, s_d1, s_d2, s_d3, s_derr, s_lerr;
  logic        s_sok;

  serdes_rx_chk dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (bus.slave),
    .clr_cnt      (clr_cnt),
    .test_rx_d0   (d0),
    .test_rx_d1   (d1),
    .test_rx_d2   (d2),
    .test_rx_d3   (d3),
    .data_err_cnt (derr),
    .link_err_cnt (lerr),
    .sync_ok      (sok)
  );

  serdes_rx_chk #(
    .SYNC_CNT (8),
    .LOSS_CNT (15)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .rx           (bus.slave),
    .clr_cnt      (clr_cnt),
    .test_rx_d0   (s_d0),
    .test_rx_d1   (s_d1),
    .test_rx_d2   (s_d2),
    .test_rx_d3   (s_d3),
    .data_err_cnt (s_derr),
    .link_err_cnt (s_lerr),
    .sync_ok      (s_sok)
  );

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic [15:0] cur;
  int          miss;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic lk, input logic clr);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    bus.rx_lock  = lk;
    clr_cnt      = clr;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    clr_cnt      = 1'b0;
  endtask

  task automatic send_run(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) send(first + 16'(i), 1'b1, 1'b0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  initial begin
    bus.rx_data  = 16'd0;
    bus.rx_valid = 1'b0;
    bus.rx_lock  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sync_ok", {15'd0, sok}, 16'd0);
    chk("rst_derr", derr, 16'd0);
    chk("rst_lerr", lerr, 16'd0);
    chk("rst_d0", d0, 16'd0);
    chk("rst_d3", d3, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pattern lock: seed word plus eight matches.
    send_run(16'h0100, 8);
    chk("lock_pre_sync", {15'd0, sok}, 16'd0);
    send(16'h0108, 1'b1, 1'b0);
    chk("lock_sync_ok", {15'd0, sok}, 16'd1);
    chk("lock_derr", derr, 16'd0);
    chk("lock_lerr", lerr, 16'd0);
    chk("lock_d0", d0, 16'h0108);
    chk("lock_d1", d1, 16'h0107);
    chk("lock_d3", d3, 16'h0105);

    // Idle gap does not advance expected.
    repeat (3) @(posedge clk);
    #1;
    send(16'h0109, 1'b1, 1'b0);
    chk("gap_derr", derr, 16'd0);
    chk("gap_sync_ok", {15'd0, sok}, 16'd1);
    chk("gap_d0", d0, 16'h0109);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_sync_ok", {15'd0, sok}, 16'd0);
    chk("arst_d0", d0, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Relock near the top of the range, then wrap through zero.
    send_run(16'hFFF5, 9);
    chk("wrap_locked", {15'd0, sok}, 16'd1);
    send_run(16'hFFFE, 4);
    chk("wrap_derr", derr, 16'd0);
    chk("wrap_sync_ok", {15'd0, sok}, 16'd1);
    chk("wrap_d0", d0, 16'h0001);
    chk("wrap_d3", d3, 16'hFFFE);

    // Single error freezes the window with the three preceding words.
    send_run(16'h0002, 17);
    send(16'h5555, 1'b1, 1'b0);
    send(16'h5556, 1'b1, 1'b0);
    send(16'h5557, 1'b1, 1'b0);
    chk("frz_derr", derr, 16'd1);
    chk("frz_sync_ok", {15'd0, sok}, 16'd1);
    chk("frz_d0", d0, 16'h5555);
    chk("frz_d1", d1, 16'h0012);
    chk("frz_d2", d2, 16'h0011);
    chk("frz_d3", d3, 16'h0010);

    // Four consecutive wrong words declare link loss.
    pulse_clr();
    chk("clr_derr", derr, 16'd0);
    send(16'h1000, 1'b1, 1'b0);
    send(16'h2000, 1'b1, 1'b0);
    send(16'h3000, 1'b1, 1'b0);
    chk("loss3_sync_ok", {15'd0, sok}, 16'd1);
    chk("loss3_lerr", lerr, 16'd0);
    send(16'h4000, 1'b1, 1'b0);
    chk("loss_derr", derr, 16'd4);
    chk("loss_lerr", lerr, 16'd1);
    chk("loss_sync_ok", {15'd0, sok}, 16'd0);
    chk("loss_refrz_d0", d0, 16'h1000);

    // Lock drop in SYNC with a wrong word: link loss only.
    send_run(16'h0200, 9);
    chk("drop_pre_sync", {15'd0, sok}, 16'd1);
    send(16'h7777, 1'b0, 1'b0);
    chk("drop_lerr", lerr, 16'd2);
    chk("drop_derr", derr, 16'd4);
    chk("drop_sync_ok", {15'd0, sok}, 16'd0);
    send_run(16'h0300, 9);
    chk("drop_resync", {15'd0, sok}, 16'd1);

    // Clear concurrent with an error drops the increment and unfreezes.
    send(16'h0999, 1'b1, 1'b1);
    chk("cclr_derr", derr, 16'd0);
    chk("cclr_lerr", lerr, 16'd0);
    send(16'h0ABC, 1'b1, 1'b0);
    chk("cclr_next_derr", derr, 16'd1);
    chk("cclr_next_d0", d0, 16'h0ABC);
    send(16'h0ABD, 1'b1, 1'b0);
    chk("cclr_hold_d0", d0, 16'h0ABC);

    // Clear with an error while unfrozen: word shifts in, window stays live.
    pulse_clr();
    send(16'h0B00, 1'b1, 1'b1);
    chk("uclr_derr", derr, 16'd0);
    chk("uclr_d0", d0, 16'h0B00);
    send(16'h0B01, 1'b1, 1'b0);
    chk("uclr_live_d0", d0, 16'h0B01);
    chk("uclr_live_d1", d1, 16'h0B00);

    // Saturation on the long-loss instance: never 15 misses in a row.
    send_run(16'h0400, 20);
    pulse_clr();
    chk("sat_start_sync", {15'd0, s_sok}, 16'd1);
    chk("sat_start_derr", s_derr, 16'd0);
    cur  = 16'h0413;
    miss = 0;
    for (int i = 0; i < 65535; i++) begin
      if (miss == 14) begin
        cur = cur + 16'd1;
        send(cur, 1'b1, 1'b0);
        miss = 0;
      end
      cur = cur + 16'd2;
      send(cur, 1'b1, 1'b0);
      miss++;
    end
    chk("sat_full", s_derr, 16'hFFFF);
    chk("sat_lerr", s_lerr, 16'd0);
    chk("sat_sync_ok", {15'd0, s_sok}, 16'd1);
    if (miss == 14) begin
      cur = cur + 16'd1;
      send(cur, 1'b1, 1'b0);
    end
    cur = cur + 16'd2;
    send(cur, 1'b1, 1'b0);
    chk("sat_hold", s_derr, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
